// File: rtl/div_wb_stage_if.sv
// rtl/div_wb_stage_if.sv - divider-side and writeback-side signal bundle for div_wb_stage
interface div_wb_stage_if #(
    parameter int LAT_W = 6
);
    logic             div_issue_i;
    logic             div_valid_i;
    logic [31:0]      div_result_i;
    logic             div_ready_o;
    logic             kill_i;
    logic             wb_valid_o;
    logic [31:0]      wb_data_o;
    logic [LAT_W-1:0] wb_lat_o;
    logic             wb_ready_i;
    logic             busy_o;
    logic             proto_err_o;

    modport slave (
        input  div_issue_i, div_valid_i, div_result_i, kill_i, wb_ready_i,
        output div_ready_o, wb_valid_o, wb_data_o, wb_lat_o, busy_o, proto_err_o
    );

    modport master (
        output div_issue_i, div_valid_i, div_result_i, kill_i, wb_ready_i,
        input  div_ready_o, wb_valid_o, wb_data_o, wb_lat_o, busy_o, proto_err_o
    );
endinterface

// File: rtl/div_wb_stage.sv
// rtl/div_wb_stage.sv - divider writeback FIFO tagging each result with issue-to-push latency
module div_wb_stage #(
    parameter int DEPTH = 2,
    parameter int LAT_W = 6
) (
    input  logic           clk,
    input  logic           rst,
    div_wb_stage_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [LAT_W-1:0] LAT_MAX = {LAT_W{1'b1}};

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, state_next;
    logic [LAT_W-1:0]  lat_cnt, lat_next;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [31:0]       data_mem [DEPTH];
    logic [LAT_W-1:0]  lat_mem  [DEPTH];
    logic              rst_q;
    logic              proto_err;
    logic              err_set;
    logic              push, pop;
    logic              not_empty;
    logic [LAT_W-1:0]  push_lat;

    // Holds div_ready_o low for the cycle following a reset edge.
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    assign not_empty        = (count != '0);
    assign bus.div_ready_o  = !rst_q && (count != CNT_W'(DEPTH));
    assign bus.wb_valid_o   = not_empty;
    assign bus.wb_data_o    = not_empty ? data_mem[rd_ptr] : 32'd0;
    assign bus.wb_lat_o     = not_empty ? lat_mem[rd_ptr]  : '0;
    assign bus.busy_o       = (state == BUSY);
    assign bus.proto_err_o  = proto_err;

    assign push     = bus.div_valid_i && bus.div_ready_o;
    assign pop      = not_empty && bus.wb_ready_i;
    assign push_lat = (state == BUSY) ? lat_cnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= state_next;
            lat_cnt <= lat_next;
        end
    end

    always_comb begin
        state_next = state;
        lat_next   = lat_cnt;
        err_set    = 1'b0;
        if (bus.kill_i) begin
            state_next = IDLE;
            lat_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.div_valid_i) err_set = 1'b1;
                    if (bus.div_issue_i) begin
                        state_next = BUSY;
                        lat_next   = LAT_W'(1);
                    end
                end
                BUSY: begin
                    if (push) begin
                        if (bus.div_issue_i) begin
                            lat_next = LAT_W'(1);
                        end else begin
                            state_next = IDLE;
                            lat_next   = '0;
                        end
                    end else begin
                        if (bus.div_issue_i) err_set = 1'b1;
                        if (lat_cnt != LAT_MAX) lat_next = lat_cnt + LAT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    lat_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (err_set) begin
            proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.kill_i) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: reads are masked by count.
    always_ff @(posedge clk) begin
        if (!rst && !bus.kill_i && push) begin
            data_mem[wr_ptr] <= bus.div_result_i;
            lat_mem[wr_ptr]  <= push_lat;
        end
    end
endmodule

// File: tb/tb_div_wb_stage.sv
// tb/tb_div_wb_stage.sv - directed self-checking bench for div_wb_stage
module tb_div_wb_stage;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    div_wb_stage_if #(.LAT_W(6)) bus ();

    div_wb_stage #(.DEPTH(2), .LAT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.div_issue_i  = 1'b0;
        bus.div_valid_i  = 1'b0;
        bus.div_result_i = 32'd0;
        bus.kill_i       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.wb_ready_i = 1'b1;
        step();
        checks++; if (bus.div_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.div_ready_o); end
        checks++; if (bus.wb_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.wb_valid_o); end
        checks++; if (bus.wb_data_o !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.wb_data_o); end
        checks++; if (bus.wb_lat_o !== 6'd0) begin failures++; $display("FAIL reset_lat got=%0d exp=0", bus.wb_lat_o); end
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
        checks++; if (bus.proto_err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.proto_err_o); end
        rst = 1'b0;
        step();
        checks++; if (bus.div_ready_o !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", bus.div_ready_o); end
    endtask

    task automatic test_basic();
        bus.wb_ready_i  = 1'b1;
        bus.div_issue_i = 1'b1;
        step();
        bus.div_issue_i = 1'b0;
        checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", bus.busy_o); end
        repeat (4) step();
        bus.div_valid_i  = 1'b1;
        bus.div_result_i = 32'h0000_0007;
        step();
        bus.div_valid_i = 1'b0;
        checks++; if (bus.wb_valid_o !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", bus.wb_valid_o); end
        checks++; if (bus.wb_data_o !== 32'h7) begin failures++; $display("FAIL basic_data got=%h exp=7", bus.wb_data_o); end
        checks++; if (bus.wb_lat_o !== 6'd5) begin failures++; $display("FAIL basic_lat got=%0d exp=5", bus.wb_lat_o); end
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b exp=0", bus.busy_o); end
        step();
        checks++; if (bus.wb_valid_o !== 1'b0) begin failures++; $display("FAIL basic_popped got=%b exp=0", bus.wb_valid_o); end
    endtask

    task automatic test_full();
        bus.wb_ready_i  = 1'b0;
        bus.div_issue_i = 1'b1;
        step();
        bus.div_valid_i  = 1'b1;
        bus.div_result_i = 32'hA;
        step();
        bus.div_result_i = 32'hB;
        step();
        bus.div_issue_i  = 1'b0;
        bus.div_result_i = 32'hC;
        checks++; if (bus.div_ready_o !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", bus.div_ready_o); end
        step();
        checks++; if (bus.div_ready_o !== 1'b0) begin failures++; $display("FAIL full_ready_hold got=%b exp=0", bus.div_ready_o); end
        checks++; if (bus.wb_data_o !== 32'hA) begin failures++; $display("FAIL full_head_a got=%h exp=a", bus.wb_data_o); end
        checks++; if (bus.wb_lat_o !== 6'd1) begin failures++; $display("FAIL full_lat_a got=%0d exp=1", bus.wb_lat_o); end
        bus.wb_ready_i = 1'b1;
        step();
        checks++; if (bus.wb_data_o !== 32'hB) begin failures++; $display("FAIL full_head_b got=%h exp=b", bus.wb_data_o); end
        checks++; if (bus.div_ready_o !== 1'b1) begin failures++; $display("FAIL full_ready_after_pop got=%b exp=1", bus.div_ready_o); end
        step();
        bus.div_valid_i = 1'b0;
        checks++; if (bus.wb_data_o !== 32'hC) begin failures++; $display("FAIL full_head_c got=%h exp=c", bus.wb_data_o); end
        checks++; if (bus.wb_lat_o !== 6'd3) begin failures++; $display("FAIL full_lat_c got=%0d exp=3", bus.wb_lat_o); end
        step();
        checks++; if (bus.wb_valid_o !== 1'b0) begin failures++; $display("FAIL full_drained got=%b exp=0", bus.wb_valid_o); end
        checks++; if (bus.proto_err_o !== 1'b0) begin failures++; $display("FAIL full_err got=%b exp=0", bus.proto_err_o); end
    endtask

    task automatic test_saturate();
        bus.wb_ready_i  = 1'b1;
        bus.div_issue_i = 1'b1;
        step();
        bus.div_issue_i = 1'b0;
        repeat (80) step();
        checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL sat_busy got=%b exp=1", bus.busy_o); end
        bus.div_valid_i  = 1'b1;
        bus.div_result_i = 32'h33;
        step();
        bus.div_valid_i = 1'b0;
        checks++; if (bus.wb_data_o !== 32'h33) begin failures++; $display("FAIL sat_data got=%h exp=33", bus.wb_data_o); end
        checks++; if (bus.wb_lat_o !== 6'd63) begin failures++; $display("FAIL sat_lat got=%0d exp=63", bus.wb_lat_o); end
        step();
    endtask

    task automatic test_back_to_back();
        bus.wb_ready_i  = 1'b0;
        bus.div_issue_i = 1'b1;
        step();
        bus.div_issue_i = 1'b0;
        step();
        bus.div_issue_i  = 1'b1;
        bus.div_valid_i  = 1'b1;
        bus.div_result_i = 32'h55;
        step();
        bus.div_issue_i = 1'b0;
        bus.div_valid_i = 1'b0;
        checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", bus.busy_o); end
        repeat (2) step();
        bus.div_valid_i  = 1'b1;
        bus.div_result_i = 32'h66;
        step();
        bus.div_valid_i = 1'b0;
        checks++; if (bus.wb_data_o !== 32'h55) begin failures++; $display("FAIL b2b_data0 got=%h exp=55", bus.wb_data_o); end
        checks++; if (bus.wb_lat_o !== 6'd2) begin failures++; $display("FAIL b2b_lat0 got=%0d exp=2", bus.wb_lat_o); end
        bus.wb_ready_i = 1'b1;
        step();
        checks++; if (bus.wb_data_o !== 32'h66) begin failures++; $display("FAIL b2b_data1 got=%h exp=66", bus.wb_data_o); end
        checks++; if (bus.wb_lat_o !== 6'd3) begin failures++; $display("FAIL b2b_lat1 got=%0d exp=3", bus.wb_lat_o); end
        step();
        checks++; if (bus.wb_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", bus.wb_valid_o); end
        checks++; if (bus.proto_err_o !== 1'b0) begin failures++; $display("FAIL b2b_err got=%b exp=0", bus.proto_err_o); end
    endtask

    task automatic test_kill();
        bus.wb_ready_i  = 1'b0;
        bus.div_issue_i = 1'b1;
        step();
        bus.div_valid_i  = 1'b1;
        bus.div_result_i = 32'h1;
        step();
        bus.div_result_i = 32'h2;
        step();
        bus.div_issue_i  = 1'b0;
        bus.kill_i       = 1'b1;
        bus.div_result_i = 32'hEE;
        step();
        bus.kill_i      = 1'b0;
        bus.div_valid_i = 1'b0;
        checks++; if (bus.wb_valid_o !== 1'b0) begin failures++; $display("FAIL kill_valid got=%b exp=0", bus.wb_valid_o); end
        checks++; if (bus.div_ready_o !== 1'b1) begin failures++; $display("FAIL kill_ready got=%b exp=1", bus.div_ready_o); end
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL kill_busy got=%b exp=0", bus.busy_o); end
        bus.div_issue_i = 1'b1;
        step();
        bus.div_issue_i  = 1'b0;
        bus.div_valid_i  = 1'b1;
        bus.div_result_i = 32'hDD;
        bus.kill_i       = 1'b1;
        step();
        bus.kill_i      = 1'b0;
        bus.div_valid_i = 1'b0;
        checks++; if (bus.wb_valid_o !== 1'b0) begin failures++; $display("FAIL kill_push_dropped got=%b exp=0", bus.wb_valid_o); end
        checks++; if (bus.proto_err_o !== 1'b0) begin failures++; $display("FAIL kill_err got=%b exp=0", bus.proto_err_o); end
    endtask

    task automatic test_proto_and_rst();
        bus.wb_ready_i   = 1'b0;
        bus.div_valid_i  = 1'b1;
        bus.div_result_i = 32'h11;
        step();
        bus.div_valid_i = 1'b0;
        checks++; if (bus.proto_err_o !== 1'b1) begin failures++; $display("FAIL proto_set got=%b exp=1", bus.proto_err_o); end
        checks++; if (bus.wb_data_o !== 32'h11) begin failures++; $display("FAIL proto_data got=%h exp=11", bus.wb_data_o); end
        checks++; if (bus.wb_lat_o !== 6'd0) begin failures++; $display("FAIL proto_lat got=%0d exp=0", bus.wb_lat_o); end
        bus.wb_ready_i  = 1'b1;
        bus.div_issue_i = 1'b1;
        step();
        bus.div_issue_i = 1'b0;
        repeat (3) step();
        checks++; if (bus.proto_err_o !== 1'b1) begin failures++; $display("FAIL proto_sticky got=%b exp=1", bus.proto_err_o); end
        bus.div_valid_i  = 1'b1;
        bus.div_result_i = 32'h22;
        bus.div_issue_i  = 1'b1;
        step();
        bus.div_valid_i = 1'b0;
        bus.div_issue_i = 1'b0;
        bus.wb_ready_i  = 1'b0;
        rst = 1'b1;
        step();
        checks++; if (bus.div_ready_o !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", bus.div_ready_o); end
        checks++; if (bus.wb_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.wb_valid_o); end
        checks++; if (bus.wb_data_o !== 32'd0) begin failures++; $display("FAIL rst_data got=%h exp=0", bus.wb_data_o); end
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy_o); end
        checks++; if (bus.proto_err_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", bus.proto_err_o); end
        rst = 1'b0;
        step();
        checks++; if (bus.div_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%b exp=1", bus.div_ready_o); end
        checks++; if (bus.wb_valid_o !== 1'b0) begin failures++; $display("FAIL rst_empty got=%b exp=0", bus.wb_valid_o); end
        bus.div_issue_i = 1'b1;
        step();
        step();
        bus.div_issue_i = 1'b0;
        step();
        checks++; if (bus.proto_err_o !== 1'b1) begin failures++; $display("FAIL busy_issue_err got=%b exp=1", bus.proto_err_o); end
        checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL busy_issue_still got=%b exp=1", bus.busy_o); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle_inputs();
        bus.wb_ready_i = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_saturate();
        test_back_to_back();
        test_kill();
        test_proto_and_rst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
